riscv_shared_div_responder: RTL and testbench

- Shared iterative divide unit serving up to NUM_CORES requesters, each running a basic single-cycle ALU with no divider.
- A core issues a request with operator and operands; the unit arbitrates round-robin, computes one division at a time, and returns the result to the winning core through a valid/ready response.
- It sits beside the cluster's cores, alongside the other shared DSP resources.

---
 rtl/riscv_defines.sv | 30 +++
 rtl/riscv_rr_arbiter.sv | 35 +++
 rtl/riscv_shared_div_responder.sv | 143 ++++++++++++++
 tb/tb_riscv_shared_div_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defines.sv
// Shared core definitions: ALU divide opcodes and the shared divider state encoding.
package riscv_defines;

    localparam int ALU_OP_WIDTH = 7;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU = 7'b0110000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV  = 7'b0110001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU = 7'b0110010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_REM  = 7'b0110011;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIX,
        RESP
    } div_state_e;

    function automatic logic div_op_signed(input logic [ALU_OP_WIDTH-1:0] op);
        return (op == ALU_DIV) || (op == ALU_REM);
    endfunction

    function automatic logic div_op_rem(input logic [ALU_OP_WIDTH-1:0] op);
        return (op == ALU_REM) || (op == ALU_REMU);
    endfunction

    function automatic logic div_op_known(input logic [ALU_OP_WIDTH-1:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/riscv_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, wrapping around to index 0.
module riscv_rr_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int CORE_ID_W = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req_i,
    input  logic [CORE_ID_W-1:0] ptr_i,
    output logic [NUM_CORES-1:0] gnt_o,
    output logic [CORE_ID_W-1:0] idx_o,
    output logic                 valid_o
);

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        // First pass covers ptr..N-1, second pass the wrapped range 0..ptr-1.
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!valid_o && req_i[i] && (CORE_ID_W'(i) >= ptr_i)) begin
                valid_o  = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = CORE_ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!valid_o && req_i[i]) begin
                valid_o  = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = CORE_ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/riscv_shared_div_responder.sv
// Shared iterative divider: round-robin arbitration across cores, one restoring
// radix-2 division at a time, result returned to the owner over valid/ready.
module riscv_shared_div_responder
    import riscv_defines::*;
#(
    parameter int NUM_CORES = 4,
    parameter int CORE_ID_W = $clog2(NUM_CORES)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CORES-1:0]              req_i,
    output logic [NUM_CORES-1:0]              gnt_o,
    input  logic [NUM_CORES*ALU_OP_WIDTH-1:0] operator_i,
    input  logic [NUM_CORES*32-1:0]           operand_a_i,
    input  logic [NUM_CORES*32-1:0]           operand_b_i,
    output logic [NUM_CORES-1:0]              rvalid_o,
    input  logic [NUM_CORES-1:0]              rready_i,
    output logic [31:0]                       result_o,
    output logic                              busy_o
);

    div_state_e              r_state, w_next_state;
    logic [CORE_ID_W-1:0]    r_rr_ptr, r_owner, w_arb_idx;
    logic [NUM_CORES-1:0]    w_arb_gnt;
    logic                    w_arb_valid, w_grant;
    logic [ALU_OP_WIDTH-1:0] w_op;
    logic [31:0]             w_a, w_b, w_abs_a, w_abs_b, w_special_res, w_fix_res;
    logic                    w_signed, w_rem, w_special;
    logic [5:0]              r_cnt;
    logic [31:0]             r_q, r_r, r_dvs, r_result;
    logic                    r_rem, r_neg_q, r_neg_r;
    logic [32:0]             w_shift, w_trial;

    riscv_rr_arbiter #(
        .NUM_CORES(NUM_CORES),
        .CORE_ID_W(CORE_ID_W)
    ) u_arb (
        .req_i  (req_i),
        .ptr_i  (r_rr_ptr),
        .gnt_o  (w_arb_gnt),
        .idx_o  (w_arb_idx),
        .valid_o(w_arb_valid)
    );

    always_comb begin
        w_op = '0;
        w_a  = '0;
        w_b  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (w_arb_idx == CORE_ID_W'(i)) begin
                w_op = operator_i[i*ALU_OP_WIDTH +: ALU_OP_WIDTH];
                w_a  = operand_a_i[i*32 +: 32];
                w_b  = operand_b_i[i*32 +: 32];
            end
        end
    end

    assign w_grant       = w_arb_valid && (r_state == IDLE) && !rst;
    assign w_signed      = div_op_signed(w_op);
    assign w_rem         = div_op_rem(w_op);
    assign w_abs_a       = (w_signed && w_a[31]) ? (~w_a + 32'd1) : w_a;
    assign w_abs_b       = (w_signed && w_b[31]) ? (~w_b + 32'd1) : w_b;
    assign w_special     = (w_b == 32'd0) ||
                           (w_signed && (w_a == 32'h8000_0000) && (w_b == 32'hFFFF_FFFF));
    assign w_special_res = (w_b == 32'd0) ? (w_rem ? w_a : 32'hFFFF_FFFF)
                                          : (w_rem ? 32'd0 : 32'h8000_0000);

    // Restoring step: shift next dividend bit into R, keep the trial difference if non-negative.
    assign w_shift   = {r_r, r_q[31]};
    assign w_trial   = w_shift - {1'b0, r_dvs};
    assign w_fix_res = r_rem ? (r_neg_r ? (~r_r + 32'd1) : r_r)
                             : (r_neg_q ? (~r_q + 32'd1) : r_q);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        gnt_o        = '0;
        rvalid_o     = '0;
        busy_o       = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    gnt_o        = w_arb_gnt;
                    w_next_state = w_special ? RESP : DIV;
                end
            end
            DIV:  if (r_cnt == 6'd31) w_next_state = FIX;
            FIX:  w_next_state = RESP;
            RESP: begin
                rvalid_o[r_owner] = 1'b1;
                if (rready_i[r_owner]) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            if (w_grant) begin
                r_owner  <= w_arb_idx;
                r_rr_ptr <= (w_arb_idx == CORE_ID_W'(NUM_CORES-1)) ? '0 : w_arb_idx + 1'b1;
                r_cnt    <= '0;
                if (w_special) r_result <= w_special_res;
            end
            if (r_state == DIV) r_cnt    <= r_cnt + 6'd1;
            if (r_state == FIX) r_result <= w_fix_res;
        end
    end

    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_q     <= w_abs_a;
            r_r     <= '0;
            r_dvs   <= w_abs_b;
            r_rem   <= w_rem;
            r_neg_q <= w_signed && (w_a[31] ^ w_b[31]);
            r_neg_r <= w_signed && w_a[31];
        end else if (r_state == DIV) begin
            r_q <= {r_q[30:0], ~w_trial[32]};
            r_r <= w_trial[32] ? w_shift[31:0] : w_trial[31:0];
        end
    end

    assign result_o = r_result;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (w_grant && !div_op_known(w_op))
            $warning("riscv_shared_div_responder: unsupported operator %h from core %0d treated as DIVU",
                     w_op, w_arb_idx);
    end
`endif

endmodule

// File: tb/tb_riscv_shared_div_responder.sv
// Directed bench for the shared divider: expected results queued at issue,
// checked against the owner's response.
module tb_riscv_shared_div_responder;
    import riscv_defines::*;

    localparam int NC  = 4;
    localparam int OPW = ALU_OP_WIDTH;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC-1:0]     req, gnt, rvalid, rready;
    logic [NC*OPW-1:0] op_bus;
    logic [NC*32-1:0]  a_bus, b_bus;
    logic [31:0]       result;
    logic              busy;

    int cyc     = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int t_gnt   = 0;

    typedef struct {
        int          core;
        logic [31:0] exp;
    } sb_t;
    sb_t sb[$];

    riscv_shared_div_responder #(.NUM_CORES(NC)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .gnt_o      (gnt),
        .operator_i (op_bus),
        .operand_a_i(a_bus),
        .operand_b_i(b_bus),
        .rvalid_o   (rvalid),
        .rready_i   (rready),
        .result_o   (result),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish, required finish within 300us");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int c, input logic [OPW-1:0] op, input logic [31:0] a, input logic [31:0] b);
        op_bus[c*OPW +: OPW] = op;
        a_bus[c*32 +: 32]    = a;
        b_bus[c*32 +: 32]    = b;
        req[c]               = 1'b1;
    endtask

    task automatic expect_rsp(input int c, input logic [31:0] exp);
        sb_t e;
        e.core = c;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic issue(input int c, input logic [OPW-1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        drive(c, op, a, b);
        expect_rsp(c, exp);
    endtask

    task automatic wait_gnt(input int c, input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 80 && !seen; k++) begin
            #1;
            if (gnt != '0) seen = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_gnt"}, 32'(gnt), 32'(1) << c);
        t_gnt = cyc;
        @(posedge clk);
        #1 req[c] = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int lat, input int hold);
        sb_t         e;
        bit          seen, stray;
        int          bad;
        logic [31:0] r0;
        logic [NC-1:0] vexp;
        seen  = 1'b0;
        stray = 1'b0;
        bad   = 0;
        if (sb.size() > 0) e = sb.pop_front();
        else begin
            e.core = 0;
            e.exp  = 'x;
        end
        vexp         = '0;
        vexp[e.core] = 1'b1;
        for (int k = 0; k < 120 && !seen; k++) begin
            @(negedge clk);
            if (rvalid != '0) seen = 1'b1;
            else if (gnt != '0) stray = 1'b1;
        end
        check({tag, "_rvalid"}, 32'(rvalid), 32'(vexp));
        check({tag, "_result"}, result, e.exp);
        check({tag, "_latency"}, 32'(cyc - t_gnt), 32'(lat));
        check({tag, "_no_gnt_while_busy"}, 32'(stray), 32'd0);
        r0 = result;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (rvalid !== vexp || result !== r0 || busy !== 1'b1 || gnt !== '0) bad++;
        end
        if (hold > 0) check({tag, "_hold_stable"}, 32'(bad), 32'd0);
        rready[e.core] = 1'b1;
        @(posedge clk);
        #1 rready = '0;
        @(negedge clk);
        check({tag, "_idle_after"}, {27'd0, rvalid, busy}, 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        req    = '0;
        rready = '0;
        op_bus = '0;
        a_bus  = '0;
        b_bus  = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt",    32'(gnt),    32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_result", result,      32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic unsigned divide / remainder on core 0
        issue(0, ALU_DIVU, 32'd100, 32'd7, 32'd14);
        wait_gnt(0, "divu");
        wait_rsp("divu", 34, 0);
        issue(0, ALU_REMU, 32'd100, 32'd7, 32'd2);
        wait_gnt(0, "remu_early_rready");
        rready[0] = 1'b1;
        repeat (5) @(negedge clk);
        rready[0] = 1'b0;
        wait_rsp("remu_early_rready", 34, 0);

        // Signed ops on core 2
        issue(2, ALU_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
        wait_gnt(2, "div_neg");
        wait_rsp("div_neg", 34, 0);
        issue(2, ALU_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
        wait_gnt(2, "rem_neg");
        wait_rsp("rem_neg", 34, 0);

        // Special cases: one cycle to response
        issue(1, ALU_DIVU, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF);
        wait_gnt(1, "divu_by0");
        wait_rsp("divu_by0", 1, 0);
        issue(1, ALU_REMU, 32'h0000_1234, 32'd0, 32'h0000_1234);
        wait_gnt(1, "remu_by0");
        wait_rsp("remu_by0", 1, 0);
        issue(3, ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        wait_gnt(3, "div_ovf");
        wait_rsp("div_ovf", 1, 0);
        issue(3, ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        wait_gnt(3, "rem_ovf");
        wait_rsp("rem_ovf", 1, 0);

        // All four cores at once: pointer currently wraps to 0, so order 0,1,2,3
        issue(0, ALU_DIVU, 32'd1000,      32'd10,          32'd100);
        issue(1, ALU_REMU, 32'd1000,      32'd7,           32'd6);
        issue(2, ALU_DIV,  32'hFFFF_FC18, 32'hFFFF_FFFD,   32'd333);
        issue(3, ALU_REM,  32'hFFFF_FC18, 32'd3,           32'hFFFF_FFFF);
        wait_gnt(0, "rr0"); wait_rsp("rr0", 34, 0);
        wait_gnt(1, "rr1"); wait_rsp("rr1", 34, 0);
        wait_gnt(2, "rr2"); wait_rsp("rr2", 34, 0);
        wait_gnt(3, "rr3"); wait_rsp("rr3", 34, 0);

        // Second round from pointer 0: core1 ahead of core3
        issue(3, ALU_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
        issue(1, ALU_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF);
        sb.delete();
        expect_rsp(1, 32'hFFFF_FFFF);
        expect_rsp(3, 32'd1);
        wait_gnt(1, "round2_c1"); wait_rsp("round2_c1", 34, 0);
        wait_gnt(3, "round2_c3"); wait_rsp("round2_c3", 34, 0);

        // Backpressure in RESP with another core waiting
        issue(0, ALU_DIVU, 32'h1234_5678, 32'h0000_0100, 32'h0012_3456);
        wait_gnt(0, "hold");
        issue(1, ALU_REMU, 32'h1234_5678, 32'h0000_0100, 32'h0000_0078);
        wait_rsp("hold", 34, 10);
        wait_gnt(1, "after_hold");
        wait_rsp("after_hold", 34, 0);

        // Reset during DIV aborts; re-arbitration restarts from pointer 0
        issue(2, ALU_DIVU, 32'd5000, 32'd50, 32'd100);
        wait_gnt(2, "abort");
        drive(3, ALU_DIV, 32'd7, 32'hFFFF_FFFE);
        repeat (9) @(negedge clk);
        rst    = 1'b1;
        req[2] = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_busy",   32'(busy),   32'd0);
        check("rst_mid_rvalid", 32'(rvalid), 32'd0);
        sb.delete();
        expect_rsp(2, 32'd100);
        expect_rsp(3, 32'hFFFF_FFFD);
        wait_gnt(2, "regrant_c2"); wait_rsp("regrant_c2", 34, 0);
        wait_gnt(3, "regrant_c3"); wait_rsp("regrant_c3", 34, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
